// File: rtl/sm_ext_uart_pkg.sv
// Shared definitions for the external-output UART transmitter: FSM state
// encoding, default parameter values and a width helper.
package sm_ext_uart_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } txState_t;

    localparam int DEF_CLK_PER_BIT = 16;
    localparam int DEF_FIFO_DEPTH  = 4;
    localparam int DEF_DATA_W      = 8;

    // $clog2 that never returns 0, so counters always get at least one bit.
    function automatic int clogMin1(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sm_sync_fifo.sv
// Small single-clock FIFO. The head entry is visible combinationally on dout
// so a consumer can take it in the same edge it pops. A push into a full
// FIFO is accepted only when a pop happens at the same edge.
module sm_sync_fifo
    import sm_ext_uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = clogMin1(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic [CW-1:0]    countReg;
    logic             pushOk;
    logic             popOk;

    assign full   = (countReg == CW'(DEPTH));
    assign empty  = (countReg == '0);
    assign popOk  = pop && !empty;
    assign pushOk = push && (!full || popOk);
    assign count  = countReg;
    assign dout   = mem[rdPtr];

    // Storage write; contents need no reset because count guards every read.
    always_ff @(posedge clk) begin
        if (!rst && pushOk) begin
            mem[wrPtr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap as DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            countReg <= '0;
        end else begin
            if (pushOk) wrPtr <= wrPtr + AW'(1);
            if (popOk)  rdPtr <= rdPtr + AW'(1);
            countReg <= countReg + CW'(pushOk) - CW'(popOk);
        end
    end

endmodule

// File: rtl/sm_ext_uart_tx.sv
// UART (8N1) transmitter fed by the CPU external output strobe. Each strobe
// queues the low DATA_W bits of wrData; queued bytes leave LSB first on txd,
// back-to-back when the FIFO still holds data at the end of a stop bit.
module sm_ext_uart_tx
    import sm_ext_uart_pkg::*;
#(
    parameter int CLK_PER_BIT = DEF_CLK_PER_BIT,
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter int DATA_W      = DEF_DATA_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] wrData,
    input  logic        wrStrobe,
    output logic        txd,
    output logic        busy,
    output logic        full,
    output logic        overflow
);

    localparam int CNTW = clogMin1(CLK_PER_BIT);
    localparam int BITW = clogMin1(DATA_W);
    localparam int FCW  = $clog2(FIFO_DEPTH + 1);

    txState_t          state;
    logic [CNTW-1:0]   cnt;
    logic [BITW-1:0]   bitIdx;
    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] headData;
    logic [FCW-1:0]    fifoCount;
    logic              fifoEmpty;
    logic              cntWrap;
    logic              popNow;
    logic              dropNow;

    assign cntWrap = (cnt == CNTW'(CLK_PER_BIT - 1));
    // Take the next byte when idle, or at the last cycle of a stop bit.
    assign popNow  = !fifoEmpty &&
                     ((state == S_IDLE) || (state == S_STOP && cntWrap));
    assign dropNow = wrStrobe && full && !popNow;

    sm_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) uFifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wrStrobe),
        .pop   (popNow),
        .din   (wrData[DATA_W-1:0]),
        .dout  (headData),
        .count (fifoCount),
        .full  (full),
        .empty (fifoEmpty)
    );

    // Frame sequencer, shift register and registered line/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            bitIdx   <= '0;
            sh       <= '0;
            txd      <= 1'b1;
            busy     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (dropNow) overflow <= 1'b1;

            case (state)
                S_IDLE: begin
                    txd  <= 1'b1;
                    busy <= 1'b0;
                    if (popNow) begin
                        sh    <= headData;
                        state <= S_START;
                        cnt   <= '0;
                        txd   <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                S_START: begin
                    busy <= 1'b1;
                    if (cntWrap) begin
                        cnt    <= '0;
                        bitIdx <= '0;
                        state  <= S_DATA;
                        txd    <= sh[0];
                    end else begin
                        cnt <= cnt + CNTW'(1);
                    end
                end
                S_DATA: begin
                    busy <= 1'b1;
                    if (cntWrap) begin
                        cnt <= '0;
                        if (bitIdx == BITW'(DATA_W - 1)) begin
                            state <= S_STOP;
                            txd   <= 1'b1;
                        end else begin
                            // Shift so the next bit is always at sh[0].
                            bitIdx <= bitIdx + BITW'(1);
                            sh     <= sh >> 1;
                            txd    <= sh[1];
                        end
                    end else begin
                        cnt <= cnt + CNTW'(1);
                    end
                end
                S_STOP: begin
                    busy <= 1'b1;
                    if (cntWrap) begin
                        cnt <= '0;
                        if (popNow) begin
                            sh    <= headData;
                            state <= S_START;
                            txd   <= 1'b0;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CNTW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    txd   <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sm_ext_uart_tx.sv
// Directed bench for sm_ext_uart_tx. Expected bytes are queued when strobes
// are driven; a line receiver decodes txd and pops/compares each frame.
module tb_sm_ext_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] wrData = '0;
    logic        wrStrobe = 1'b0;
    logic        txd;
    logic        busy;
    logic        full;
    logic        overflow;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  expq [$];

    sm_ext_uart_tx #(
        .CLK_PER_BIT (CPB),
        .FIFO_DEPTH  (DEPTH),
        .DATA_W      (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wrData   (wrData),
        .wrStrobe (wrStrobe),
        .txd      (txd),
        .busy     (busy),
        .full     (full),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Edge index: after posedge Ek, cyc == k.
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive a one-cycle strobe so that it is sampled at posedge number e.
    // Must be called from a negedge with cyc <= e-1.
    task automatic strobeAt(input int e, input logic [31:0] v);
        while (cyc < e - 1) @(negedge clk);
        wrData   = v;
        wrStrobe = 1'b1;
        @(negedge clk);
        wrStrobe = 1'b0;
    endtask

    // Wait (bounded) for busy to fall; returns the edge index where it fell.
    task automatic waitIdle(input int limit, output int dropCyc);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (busy === 1'b0) break;
        end
        check("idle_within_bound", 32'(busy), 32'd0);
        dropCyc = cyc;
    endtask

    // Line receiver: samples each bit near its centre, aborts on reset.
    logic       rxActive = 1'b0;
    int         rxT = 0;
    int         rxK = 0;
    logic [7:0] rxSh = '0;

    always @(negedge clk) begin
        if (rst) begin
            rxActive = 1'b0;
        end else if (!rxActive) begin
            if (txd === 1'b0) begin
                rxActive = 1'b1;
                rxT = 0;
            end
        end else begin
            rxT++;
            if (rxT >= CPB && (rxT % CPB) == (CPB / 2 - 1)) begin
                rxK = rxT / CPB - 1;
                if (rxK < 8) begin
                    rxSh[rxK[2:0]] = txd;
                end else begin
                    check("rx_stop_bit", 32'(txd), 32'd1);
                    check("rx_frame_expected", 32'(expq.size() != 0), 32'd1);
                    if (expq.size() != 0) check("rx_byte", 32'(rxSh), 32'(expq.pop_front()));
                    $display("rx byte %02h at edge %0d", rxSh, cyc);
                    rxActive = 1'b0;
                end
            end
        end
    end

    initial begin
        int e;
        int d;
        int bad;

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: single byte, start-bit latency and frame length
        e = cyc + 1;
        expq.push_back(8'h55);
        strobeAt(e, 32'h0000_0155);
        check("t1_txd_at_e0", 32'(txd), 32'd1);
        @(negedge clk);
        check("t1_txd_start_at_e1", 32'(txd), 32'd0);
        check("t1_busy_at_e1", 32'(busy), 32'd1);
        while (cyc < e + 5) @(negedge clk);
        check("t1_bit0", 32'(txd), 32'd1);
        while (cyc < e + 9) @(negedge clk);
        check("t1_bit1", 32'(txd), 32'd0);
        waitIdle(200, d);
        check("t1_busy_drop_edge", 32'(d - e), 32'(1 + FRAME));
        check("t1_queue_drained", 32'(expq.size()), 32'd0);

        // 2: upper bits ignored
        e = cyc + 1;
        expq.push_back(8'hA5);
        strobeAt(e, 32'hDEAD_BEA5);
        waitIdle(200, d);
        check("t2_busy_drop_edge", 32'(d - e), 32'(1 + FRAME));
        check("t2_queue_drained", 32'(expq.size()), 32'd0);

        // 3: burst of six, depth four: fifth accepted byte fills, sixth dropped
        e = cyc + 1;
        for (int i = 0; i < 6; i++) begin
            if (i < 5) expq.push_back(8'(8'h11 + i));
            strobeAt(e + i, 32'(8'h11 + i));
        end
        check("t3_overflow_at_e5", 32'(overflow), 32'd1);
        check("t3_full_at_e5", 32'(full), 32'd1);
        waitIdle(600, d);
        check("t3_back_to_back_total", 32'(d - e), 32'(1 + 5 * FRAME));
        check("t3_queue_drained", 32'(expq.size()), 32'd0);
        check("t3_overflow_sticky", 32'(overflow), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t3_overflow_cleared", 32'(overflow), 32'd0);

        // 4: push while full at the STOP->START pop edge is accepted
        e = cyc + 1;
        strobeAt(e, 32'h41);
        expq.push_back(8'h41);
        for (int i = 0; i < 4; i++) begin
            expq.push_back(8'(8'h42 + i));
            strobeAt(e + 2 + i, 32'(8'h42 + i));
        end
        while (cyc < e + FRAME) @(negedge clk);
        check("t4_full_before_pop", 32'(full), 32'd1);
        expq.push_back(8'h77);
        strobeAt(e + 1 + FRAME, 32'h77);
        check("t4_overflow_clear", 32'(overflow), 32'd0);
        check("t4_still_full", 32'(full), 32'd1);
        waitIdle(800, d);
        check("t4_total", 32'(d - e), 32'(1 + 6 * FRAME));
        check("t4_queue_drained", 32'(expq.size()), 32'd0);
        check("t4_overflow_end", 32'(overflow), 32'd0);

        // 5: reset during data bit 3 with two bytes queued
        e = cyc + 1;
        strobeAt(e, 32'h3C);
        strobeAt(e + 1, 32'h5A);
        strobeAt(e + 2, 32'h6B);
        while (cyc < e + 17) @(negedge clk);
        check("t5_txd_bit3_before_rst", 32'(txd), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("t5_rst_txd", 32'(txd), 32'd1);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_full", 32'(full), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (3 * FRAME) begin
            @(negedge clk);
            if (txd !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("t5_no_frames_after_rst", 32'(bad), 32'd0);
        e = cyc + 1;
        expq.push_back(8'hC3);
        strobeAt(e, 32'h0000_01C3);
        waitIdle(200, d);
        check("t5_new_frame_length", 32'(d - e), 32'(1 + FRAME));
        check("t5_queue_drained", 32'(expq.size()), 32'd0);

        // 6: strobe during reset is ignored
        rst = 1'b1;
        wrData = 32'h99;
        wrStrobe = 1'b1;
        @(negedge clk);
        wrStrobe = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (txd !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("t6_line_idle", 32'(bad), 32'd0);
        check("t6_overflow", 32'(overflow), 32'd0);
        check("t6_full", 32'(full), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
